mdu_hilo: RTL

Multiply/divide unit and HI/LO register file for the Citrus CPU. Sits directly downstream of the combinational `multiplier`:
- drives its `a`/`b`/`symbol` inputs from registered operands;
- captures its 64-bit `o` into HI/LO.

Also implements MIPS DIV/DIVU as a 32-iteration restoring divider, plus MTHI/MTLO. It exposes `busy` so the pipeline stalls MFHI/MFLO and further MD ops.

---
 rtl/mdu_hilo.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/mdu_hilo.sv
// HI/LO register file with multiply sequencing and a 32-step restoring divider.
// Drives an external combinational multiplier and captures its product into HI/LO.
module mdu_hilo #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   rs_val,
  input  logic [WIDTH-1:0]   rt_val,
  input  logic               flush,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic               mul_symbol,
  input  logic [2*WIDTH-1:0] mul_o,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DZ   = 3'd4
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic               mul_sym_q, mul_sym_d;
  logic               done_q, done_d, dz_q, dz_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d, dvd_q, dvd_d, dvs_q, dvs_d;
  logic               q_neg_q, q_neg_d, r_neg_q, r_neg_d;

  logic               is_signed;
  logic [WIDTH-1:0]   rs_abs, rt_abs;
  logic [WIDTH:0]     rem_shift, trial;
  logic               q_bit;

  assign is_signed = (op == OP_DIV);
  assign rs_abs    = (is_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign rt_abs    = (is_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;

  // The dividend register shifts out MSB-first and fills with quotient bits.
  assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, dvs_q};
  assign q_bit     = ~trial[WIDTH];

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    mul_sym_d = mul_sym_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              mul_a_d   = rs_val;
              mul_b_d   = rt_val;
              mul_sym_d = (op == OP_MULT);
              state_d   = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              if (rt_val == '0) begin
                state_d = S_DZ;
              end else begin
                dvd_d   = rs_abs;
                dvs_d   = rt_abs;
                q_neg_d = is_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                r_neg_d = is_signed & rs_val[WIDTH-1];
                rem_d   = '0;
                cnt_d   = '0;
                state_d = S_DIV;
              end
            end
            OP_MTHI: begin
              hi_d   = rs_val;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = rs_val;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        state_d = S_IDLE;
        if (!flush) begin
          {hi_d, lo_d} = mul_o;
          done_d       = 1'b1;
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          rem_d = q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], q_bit};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == {CNT_W{1'b1}}) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          lo_d   = q_neg_q ? -dvd_q : dvd_q;
          hi_d   = r_neg_q ? -rem_q : rem_q;
          done_d = 1'b1;
        end
      end
      S_DZ: begin
        state_d = S_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          dz_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      mul_sym_q <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      mul_sym_q <= mul_sym_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
    end
  end

  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign mul_symbol  = mul_sym_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
